// File: rtl/reg_save_restore.sv
// Context save/restore sequencer: spills the register file to data memory
// (SAVE) or fills it back (RESTORE), one register per cycle, at a fixed latency.
module reg_save_restore #(
  parameter int NREG = 8,
  parameter int DW   = 8,
  parameter int AW   = 8,
  localparam int RW  = $clog2(NREG)
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            Start,
  input  logic            Op,
  input  logic [AW-1:0]   Base,
  input  logic [NREG-1:0] Mask,
  output logic            Busy,
  output logic            Done,
  output logic [RW-1:0]   Rf_Ra,
  input  logic [DW-1:0]   Rf_RdatA,
  output logic            Rf_Wen,
  output logic [RW-1:0]   Rf_Wd,
  output logic [DW-1:0]   Rf_Wdat,
  output logic [AW-1:0]   Mem_Addr,
  output logic            Mem_Wen,
  output logic [DW-1:0]   Mem_Wdat,
  input  logic [DW-1:0]   Mem_Rdat
);

  // Counter must reach NREG: RESTORE needs one extra cycle for the read latency.
  localparam int CW = $clog2(NREG + 1);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   idx;
  logic [AW-1:0]   base_q;
  logic [NREG-1:0] mask_q;
  logic            save_last, rest_last, rest_issue_last;

  assign save_last       = (idx == CW'(NREG - 1));
  assign rest_last       = (idx == CW'(NREG));
  assign rest_issue_last = (idx == CW'(NREG - 1));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d  = state;
    Busy     = 1'b0;
    Done     = 1'b0;
    Mem_Wen  = 1'b0;
    Rf_Wen   = 1'b0;
    Mem_Wdat = Rf_RdatA;
    Rf_Wdat  = Mem_Rdat;
    case (state)
      IDLE: begin
        if (Start) state_d = Op ? RESTORE : SAVE;
      end
      SAVE: begin
        Busy    = 1'b1;
        Mem_Wen = mask_q[RW'(idx)];
        if (save_last) state_d = DONE;
      end
      RESTORE: begin
        Busy = 1'b1;
        // Write side trails the issue side by the memory's one-cycle read latency.
        if (idx != '0) Rf_Wen = mask_q[RW'(idx - CW'(1))];
        if (rest_last) state_d = DONE;
      end
      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      base_q   <= '0;
      mask_q   <= '0;
      Rf_Ra    <= '0;
      Rf_Wd    <= '0;
      Mem_Addr <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (Start) begin
            base_q   <= Base;
            mask_q   <= Mask;
            idx      <= '0;
            Rf_Ra    <= '0;
            Mem_Addr <= Base;
          end
        end
        SAVE: begin
          if (!save_last) begin
            idx      <= idx + CW'(1);
            Rf_Ra    <= RW'(idx + CW'(1));
            Mem_Addr <= base_q + AW'(idx + CW'(1));
          end
        end
        RESTORE: begin
          if (!rest_last) begin
            idx   <= idx + CW'(1);
            Rf_Wd <= RW'(idx);
            if (!rest_issue_last) Mem_Addr <= base_q + AW'(idx + CW'(1));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_save_restore.sv
// Directed bench for reg_save_restore with a behavioural register file
// (combinational read) and a synchronous-read data memory.
module tb_reg_save_restore;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Start = 1'b0;
  logic       Op = 1'b0;
  logic [7:0] Base = 8'h00;
  logic [7:0] Mask = 8'h00;
  logic       Busy, Done, Rf_Wen, Mem_Wen;
  logic [2:0] Rf_Ra, Rf_Wd;
  logic [7:0] Rf_RdatA, Rf_Wdat, Mem_Addr, Mem_Wdat, Mem_Rdat;

  reg_save_restore dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .Base(Base), .Mask(Mask),
    .Busy(Busy), .Done(Done), .Rf_Ra(Rf_Ra), .Rf_RdatA(Rf_RdatA),
    .Rf_Wen(Rf_Wen), .Rf_Wd(Rf_Wd), .Rf_Wdat(Rf_Wdat),
    .Mem_Addr(Mem_Addr), .Mem_Wen(Mem_Wen), .Mem_Wdat(Mem_Wdat), .Mem_Rdat(Mem_Rdat)
  );

  always #5 Clk = ~Clk;

  logic [7:0] mem [256];
  logic [7:0] rf  [8];
  logic       ld_mem = 1'b0, ld_rf = 1'b0;
  logic [7:0] ld_addr = 8'h00, ld_data = 8'h00;
  int         done_total = 0, memw_total = 0, rfw_total = 0;

  always @(posedge Clk) begin
    Mem_Rdat <= mem[Mem_Addr];
    if (Mem_Wen === 1'b1) begin
      mem[Mem_Addr] <= Mem_Wdat;
      memw_total    <= memw_total + 1;
    end else if (ld_mem) mem[ld_addr] <= ld_data;
    if (Rf_Wen === 1'b1) begin
      rf[Rf_Wd] <= Rf_Wdat;
      rfw_total <= rfw_total + 1;
    end else if (ld_rf) rf[ld_addr[2:0]] <= ld_data;
    if (Done === 1'b1) done_total <= done_total + 1;
  end

  assign Rf_RdatA = rf[Rf_Ra];

  int         checks = 0, failures = 0;
  logic [7:0] addr_log [16];
  logic [7:0] exp_rf [8];
  int         b, d, n, snap_m, snap_r, snap_d;

  task automatic load_mem(input logic [7:0] a, input logic [7:0] v);
    @(negedge Clk); ld_mem = 1'b1; ld_addr = a; ld_data = v;
    @(negedge Clk); ld_mem = 1'b0;
  endtask

  task automatic load_rf(input logic [7:0] a, input logic [7:0] v);
    @(negedge Clk); ld_rf = 1'b1; ld_addr = a; ld_data = v;
    @(negedge Clk); ld_rf = 1'b0;
  endtask

  // Pulse Start for one sampled edge T, then scramble the request inputs.
  // Returns at the negedge of cycle T+1.
  task automatic issue(input logic op, input logic [7:0] base, input logic [7:0] mask);
    @(negedge Clk); Start = 1'b1; Op = op; Base = base; Mask = mask;
    @(negedge Clk); Start = 1'b0; Op = ~op; Base = ~base; Mask = ~mask;
  endtask

  // Samples cycles T+1 .. T+n (first sample taken immediately).
  task automatic observe(input int ncyc, output int busy_n, output int done_at, output int done_n);
    busy_n = 0; done_at = -1; done_n = 0;
    for (int k = 1; k <= ncyc; k++) begin
      if (k > 1) @(negedge Clk);
      addr_log[k] = Mem_Addr;
      if (Busy) busy_n++;
      if (Done) begin done_n++; if (done_at < 0) done_at = k; end
      checks++;
      if ((Busy & Done) !== 1'b0) begin
        failures++; $display("FAIL busy_done_overlap: cycle T+%0d Busy=%b Done=%b want not both", k, Busy, Done);
      end
    end
  endtask

  task automatic test_reset();
    Start = 1'b1; Op = 1'b0; Base = 8'h33; Mask = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      checks++;
      if ({Busy, Done, Mem_Wen, Rf_Wen} !== 4'b0 || Mem_Addr !== 8'h00 || Rf_Ra !== 3'd0 || Rf_Wd !== 3'd0) begin
        failures++;
        $display("FAIL reset_outputs: Busy=%b Done=%b Mem_Wen=%b Rf_Wen=%b Mem_Addr=%h Rf_Ra=%0d Rf_Wd=%0d want all 0",
                 Busy, Done, Mem_Wen, Rf_Wen, Mem_Addr, Rf_Ra, Rf_Wd);
      end
    end
    @(negedge Clk); Rst_n = 1'b1; Start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0) begin
        failures++; $display("FAIL reset_release_idle: Busy=%b Done=%b want 0 0", Busy, Done);
      end
    end
  endtask

  task automatic test_save();
    for (int i = 0; i < 8; i++) load_rf(8'(i), 8'hA0 + 8'(i));
    snap_m = memw_total;
    issue(1'b0, 8'h10, 8'hFF);
    observe(12, b, d, n);
    checks++; if (b !== 8) begin failures++; $display("FAIL save_busy_cycles: got %0d want 8", b); end
    checks++; if (d !== 9 || n !== 1) begin failures++; $display("FAIL save_done: at T+%0d count %0d want T+9 count 1", d, n); end
    checks++; if (memw_total - snap_m !== 8) begin failures++; $display("FAIL save_write_count: got %0d want 8", memw_total - snap_m); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[8'h10 + 8'(i)] !== 8'hA0 + 8'(i)) begin
        failures++; $display("FAIL save_mem[%0d]: got %h want %h", i, mem[8'h10 + 8'(i)], 8'hA0 + 8'(i));
      end
    end
  endtask

  task automatic test_restore_wrap();
    for (int i = 0; i < 8; i++) load_rf(8'(i), 8'h30 + 8'(i));
    for (int i = 0; i < 8; i++) load_mem(8'hFE + 8'(i), 8'(i + 1));
    snap_r = rfw_total; snap_m = memw_total;
    issue(1'b1, 8'hFE, 8'h5A);
    observe(12, b, d, n);
    checks++; if (b !== 9) begin failures++; $display("FAIL restore_busy_cycles: got %0d want 9", b); end
    checks++; if (d !== 10 || n !== 1) begin failures++; $display("FAIL restore_done: at T+%0d count %0d want T+10 count 1", d, n); end
    checks++; if (rfw_total - snap_r !== 4 || memw_total !== snap_m) begin
      failures++; $display("FAIL restore_write_counts: rf %0d mem %0d want 4 0", rfw_total - snap_r, memw_total - snap_m);
    end
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (addr_log[k] !== 8'hFE + 8'(k - 1)) begin
        failures++; $display("FAIL restore_addr T+%0d: got %h want %h", k, addr_log[k], 8'hFE + 8'(k - 1));
      end
    end
    exp_rf = '{8'h30, 8'h02, 8'h32, 8'h04, 8'h05, 8'h35, 8'h07, 8'h37};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rf[i] !== exp_rf[i]) begin failures++; $display("FAIL restore_r%0d: got %h want %h", i, rf[i], exp_rf[i]); end
    end
  endtask

  task automatic test_start_ignored();
    snap_r = rfw_total;
    issue(1'b0, 8'h40, 8'hFF);
    b = 0; d = -1; n = 0;
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) @(negedge Clk);
      if (Busy) b++;
      if (Done) begin n++; if (d < 0) d = k; end
      if (k == 3 || k == 9) begin Start = 1'b1; Op = 1'b1; Base = 8'h80; Mask = 8'h00; end
      else Start = 1'b0;
    end
    checks++; if (b !== 8) begin failures++; $display("FAIL ignore_busy_cycles: got %0d want 8", b); end
    checks++; if (d !== 9 || n !== 1) begin failures++; $display("FAIL ignore_done: at T+%0d count %0d want T+9 count 1", d, n); end
    checks++; if (rfw_total !== snap_r) begin failures++; $display("FAIL ignore_rf_writes: got %0d want 0", rfw_total - snap_r); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[8'h40 + 8'(i)] !== exp_rf[i]) begin
        failures++; $display("FAIL ignore_mem[%0d]: got %h want %h", i, mem[8'h40 + 8'(i)], exp_rf[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 8; i++) load_rf(8'(i), 8'h50 + 8'(i));
    for (int i = 0; i < 8; i++) load_mem(8'h20 + 8'(i), 8'hC0 + 8'(i));
    snap_d = done_total;
    issue(1'b1, 8'h20, 8'hFF);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin failures++; $display("FAIL abort_idle: Busy=%b Done=%b want 0 0", Busy, Done); end
    Rst_n = 1'b1;
    repeat (6) @(negedge Clk);
    checks++; if (done_total !== snap_d) begin failures++; $display("FAIL abort_no_done: got %0d pulses want 0", done_total - snap_d); end
    exp_rf = '{8'hC0, 8'hC1, 8'hC2, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rf[i] !== exp_rf[i]) begin failures++; $display("FAIL abort_r%0d: got %h want %h", i, rf[i], exp_rf[i]); end
    end
    issue(1'b0, 8'h60, 8'hFF);
    observe(12, b, d, n);
    checks++; if (b !== 8 || d !== 9 || n !== 1) begin
      failures++; $display("FAIL abort_resave: busy %0d done T+%0d count %0d want 8 T+9 1", b, d, n);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[8'h60 + 8'(i)] !== exp_rf[i]) begin
        failures++; $display("FAIL abort_resave_mem[%0d]: got %h want %h", i, mem[8'h60 + 8'(i)], exp_rf[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    snap_r = rfw_total;
    issue(1'b0, 8'h70, 8'hFF);
    observe(9, b, d, n);
    checks++; if (b !== 8 || d !== 9) begin failures++; $display("FAIL b2b_save: busy %0d done T+%0d want 8 T+9", b, d); end
    issue(1'b1, 8'h70, 8'h00);
    observe(12, b, d, n);
    checks++; if (b !== 9) begin failures++; $display("FAIL b2b_restore_busy: got %0d want 9", b); end
    checks++; if (d !== 10 || n !== 1) begin failures++; $display("FAIL b2b_restore_done: at T+%0d count %0d want T+10 count 1", d, n); end
    checks++; if (rfw_total !== snap_r) begin failures++; $display("FAIL b2b_rf_writes: got %0d want 0", rfw_total - snap_r); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[8'h70 + 8'(i)] !== exp_rf[i] || rf[i] !== exp_rf[i]) begin
        failures++; $display("FAIL b2b_data[%0d]: mem %h rf %h want %h", i, mem[8'h70 + 8'(i)], rf[i], exp_rf[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_save();
    test_restore_wrap();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
